// File: rtl/joybus_tx_serializer.sv
// Joybus transmitter: serialises 1..MAX_BYTES bytes MSB-first plus a console or controller stop bit
// using 4-level line encoding. Define JOYBUS_TX_GAP_EN to add an idle GAP state after each frame.
module joybus_tx_serializer #(
    parameter  int LEVEL_WIDTH = 2,
    parameter  int MAX_BYTES   = 4,
    parameter  int GAP_CYCLES  = 16,
    localparam int CNT_W       = $clog2(MAX_BYTES + 1)
) (
    input  logic                   sample_clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       byte_count,
    input  logic                   stop_type,
    input  logic [MAX_BYTES*8-1:0] data_in,
    output logic                   data_tx,
    output logic                   data_oe,
    output logic                   busy,
    output logic                   done
);

    localparam int DATA_W = MAX_BYTES * 8;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int LVL_W  = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVEL_WIDTH - 1);
`ifdef JOYBUS_TX_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [LVL_W-1:0]    r_levelCnt;
    logic [LVL_W-1:0]    w_levelCntNext;
    logic [1:0]          r_levelIdx;
    logic [1:0]          w_levelIdxNext;
    logic [BIT_W-1:0]    r_bitCnt;
    logic [BIT_W-1:0]    w_bitCntNext;
    logic [BIT_W-1:0]    r_lastBit;
    logic [BIT_W-1:0]    w_lastBitNext;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shiftNext;
    logic                r_stopType;
    logic                w_stopTypeNext;
`ifdef JOYBUS_TX_GAP_EN
    logic [GAP_W-1:0]    r_gapCnt;
    logic [GAP_W-1:0]    w_gapCntNext;
`endif

    logic                r_dataTx;
    logic                r_dataOe;
    logic                r_busy;
    logic                r_done;
    logic                w_txNext;
    logic                w_oeNext;
    logic                w_busyNext;
    logic                w_doneNext;

    logic [CNT_W-1:0]    w_byteClamp;
    logic [BIT_W-1:0]    w_lastBitIn;
    logic                w_levelEnd;
    logic                w_bitEnd;

    // Oversized requests are clamped; a zero count leaves the last-bit value unused.
    assign w_byteClamp = (byte_count > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : byte_count;
    assign w_lastBitIn = BIT_W'((int'(w_byteClamp) * 8) - 1);
    assign w_levelEnd  = (r_levelCnt == LVL_LAST);
    assign w_bitEnd    = w_levelEnd && (r_levelIdx == 2'd3);

    always_comb begin
        w_stateNext    = r_state;
        w_levelCntNext = r_levelCnt;
        w_levelIdxNext = r_levelIdx;
        w_bitCntNext   = r_bitCnt;
        w_lastBitNext  = r_lastBit;
        w_shiftNext    = r_shift;
        w_stopTypeNext = r_stopType;
`ifdef JOYBUS_TX_GAP_EN
        w_gapCntNext   = r_gapCnt;
`endif

        if ((r_state == S_DATA) || (r_state == S_STOP)) begin
            if (w_levelEnd) begin
                w_levelCntNext = '0;
                w_levelIdxNext = r_levelIdx + 2'd1;
            end else begin
                w_levelCntNext = r_levelCnt + LVL_W'(1);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_levelCntNext = '0;
                    w_levelIdxNext = '0;
                    w_bitCntNext   = '0;
                    w_lastBitNext  = w_lastBitIn;
                    w_shiftNext    = data_in;
                    w_stopTypeNext = stop_type;
                    w_stateNext    = (w_byteClamp == '0) ? S_STOP : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bitEnd) begin
                    if (r_bitCnt == r_lastBit) begin
                        w_stateNext = S_STOP;
                    end else begin
                        w_bitCntNext = r_bitCnt + BIT_W'(1);
                        w_shiftNext  = {r_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
            S_STOP: begin
                if (w_bitEnd) begin
`ifdef JOYBUS_TX_GAP_EN
                    w_stateNext  = S_GAP;
                    w_gapCntNext = '0;
`else
                    w_stateNext  = S_IDLE;
`endif
                end
            end
`ifdef JOYBUS_TX_GAP_EN
            S_GAP: begin
                if (r_gapCnt == GAP_LAST) begin
                    w_stateNext = S_IDLE;
                end else begin
                    w_gapCntNext = r_gapCnt + GAP_W'(1);
                end
            end
`endif
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Line levels are decoded from next-state values so the pad outputs stay registered.
    always_comb begin
        w_txNext = 1'b1;
        w_oeNext = 1'b0;
        case (w_stateNext)
            S_DATA: begin
                w_oeNext = 1'b1;
                case (w_levelIdxNext)
                    2'd0:    w_txNext = 1'b0;
                    2'd3:    w_txNext = 1'b1;
                    default: w_txNext = w_shiftNext[DATA_W-1];
                endcase
            end
            S_STOP: begin
                case (w_levelIdxNext)
                    2'd0: begin
                        w_oeNext = 1'b1;
                        w_txNext = 1'b0;
                    end
                    2'd1: begin
                        w_oeNext = 1'b1;
                        w_txNext = ~w_stopTypeNext;
                    end
                    2'd2: begin
                        w_oeNext = 1'b1;
                        w_txNext = 1'b1;
                    end
                    default: begin
                        w_oeNext = 1'b0;
                        w_txNext = 1'b1;
                    end
                endcase
            end
            default: begin
                w_oeNext = 1'b0;
                w_txNext = 1'b1;
            end
        endcase
        w_busyNext = (w_stateNext != S_IDLE);
        w_doneNext = (r_state != S_IDLE) && (w_stateNext == S_IDLE);
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_levelCnt <= '0;
            r_levelIdx <= '0;
            r_bitCnt   <= '0;
            r_lastBit  <= '0;
            r_shift    <= '0;
            r_stopType <= 1'b0;
`ifdef JOYBUS_TX_GAP_EN
            r_gapCnt   <= '0;
`endif
            r_dataTx   <= 1'b1;
            r_dataOe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_levelCnt <= w_levelCntNext;
            r_levelIdx <= w_levelIdxNext;
            r_bitCnt   <= w_bitCntNext;
            r_lastBit  <= w_lastBitNext;
            r_shift    <= w_shiftNext;
            r_stopType <= w_stopTypeNext;
`ifdef JOYBUS_TX_GAP_EN
            r_gapCnt   <= w_gapCntNext;
`endif
            r_dataTx   <= w_txNext;
            r_dataOe   <= w_oeNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
        end
    end

    assign data_tx = r_dataTx;
    assign data_oe = r_dataOe;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: doc/joybus_tx_serializer.md
Name: joybus_tx_serializer

Overview:
- Parametrised Joybus transmitter: serialises 1..MAX_BYTES bytes MSB-first, then one stop bit, using 4-level line encoding.
- Generalises the fixed 2-cycle-level, single-buffer encoder to configurable level width, frame length and stop-bit type, with a start/busy/done handshake.
- Used by both the fake-controller reply path (controller stop) and console-side test drivers (console stop).
- Drives the tri-state pad through data_tx/data_oe; the pad wrapper resolves Z.

Parameters:
- LEVEL_WIDTH, 2, sample_clk cycles per line level; must be >= 1. BIT_WIDTH = 4*LEVEL_WIDTH.
- MAX_BYTES, 4, capacity of data_in in bytes. CNT_W = $clog2(MAX_BYTES+1), derived localparam.
- GAP_CYCLES, 16, minimum idle cycles between frames; used only with the optional feature.

Ports:
- sample_clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  frame request; sampled only when busy=0
- byte_count  in  CNT_W  bytes to send; sampled with start
- stop_type  in  1  0 = console stop (L,H,H,Z), 1 = controller stop (L,L,H,Z); sampled with start
- data_in  in  MAX_BYTES*8  payload; first byte = data_in[MAX_BYTES*8-1 -: 8]; sampled with start
- data_tx  out  1  line value while data_oe=1
- data_oe  out  1  1 = drive data_tx, 0 = release (Z)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, reset_n=0): state IDLE, data_tx=1, data_oe=0, busy=0, done=0. Counters and shift register cleared. Takes effect immediately mid-frame; no stop bit is emitted.
- Encoding, per bit, 4 levels each LEVEL_WIDTH cycles:
  - logical 0 = L,L,L,H
  - logical 1 = L,H,H,H
  - console stop = L,H,H,Z
  - controller stop = L,L,H,Z
  - L/H: data_oe=1, data_tx=0/1. Z: data_oe=0, data_tx=1.
- States: IDLE -> DATA -> STOP -> (GAP) -> IDLE.
- IDLE: on rising edge with start=1, latch data_in, byte_count, stop_type. busy=1 from the next cycle. The first level appears on the outputs in that same next cycle (latency 1).
- byte_count=0: skip DATA, go directly to STOP.
- byte_count > MAX_BYTES: clamp to MAX_BYTES.
- DATA: shift register emits MSB first. Level counter 0..LEVEL_WIDTH-1; level index 0..3; bit counter 0..8*N-1. After the last level of bit 8*N-1, go to STOP.
- STOP: emit the selected stop pattern. After the final Z level, go to IDLE.
- done=1 for exactly the first cycle back in IDLE; busy=0 in that cycle.
- Frame length = (8*N+1)*BIT_WIDTH cycles of busy=1.
- start while busy=1: ignored, with no queuing. start in the done cycle: accepted (back-to-back frames).
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro JOYBUS_TX_GAP_EN.
- Defined: after STOP, enter GAP for GAP_CYCLES cycles with busy=1, data_oe=0, data_tx=1. done pulses on the first IDLE cycle after GAP; start is ignored during GAP.
- Undefined: no GAP state; STOP goes directly to IDLE as above, and GAP_CYCLES is unused.

Test Plan:
- LEVEL_WIDTH=2, MAX_BYTES=4: start with byte_count=3, data_in=32'h05000000, stop_type=1.
  - busy=1 for exactly 200 cycles.
  - First 8 cycles are data_oe=1, data_tx=0,0,0,0,0,0,1,1 (bit 0).
  - Bits 5 and 7 read L,H,H,H.
  - Last 8 cycles are 0,0,0,0,1,1,Z,Z.
  - done pulses once.
- byte_count=4, data_in=32'h00000000, stop_type=0: 264 busy cycles; all 32 data bits L,L,L,H; stop bit L,H,H,Z.
- byte_count=0: only a stop bit, 8 busy cycles. byte_count=7 with MAX_BYTES=4: clamped, 264 cycles.
- start pulsed mid-frame and with different data_in: frame unaffected. start asserted in the done cycle: second frame begins the next cycle with no idle gap.
- reset_n dropped at cycle 50 of a frame: data_oe=0, busy=0, done=0 asynchronously. After release, a new start produces a correct full frame.
- With JOYBUS_TX_GAP_EN and GAP_CYCLES=16: done arrives 16 cycles after the stop bit ends; start during the gap is ignored.
